fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Parametrised instruction-fetch front end. Successor to the single-request fetcher.
- Issues pipelined, in-order word reads on an OBI-style memory port (proc_req/mem_rdy/valid) with up to MAX_OUTSTANDING requests in flight.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO.
- Supports PC redirect (branch/jump flush) with discard of stale in-flight responses. Sits between the PC/hazard logic and the instruction memory wrapper.

Parameters:
- XLEN, 32, instruction/address width.
- DEPTH, 4, prefetch FIFO entries (power of 2, ≥2).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests (1..DEPTH).
- RESET_PC, 32'h00400000, first fetch address after reset.

Ports:
- CLK  in  1  clock.
- RSTn  in  1  synchronous active-low reset.
- redirect_i  in  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  in  XLEN  new fetch PC, word-aligned.
- instr_ready_i  in  1  consumer accepts instr_o this cycle.
- instr_valid_o  out  1  instr_o/instr_pc_o hold a valid instruction.
- instr_o  out  XLEN  fetched instruction.
- instr_pc_o  out  XLEN  PC of instr_o.
- busy_o  out  1  high when instr_valid_o is low (consumer must stall).
- proc_req_o  out  1  memory request.
- mem_rdy_i  in  1  memory accepts the request (handshake = proc_req_o & mem_rdy_i).
- addr_o  out  XLEN  request address.
- we_o  out  1  constant 0.
- wdata_o  out  XLEN  constant 0.
- rdata_i  in  XLEN  response data.
- valid_i  in  1  response strobe; responses return in request order.

Behaviour:
- Reset (RSTn=0 at posedge):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0.
  - Outputs: proc_req_o=0, instr_valid_o=0, busy_o=1, instr_o=0, instr_pc_o=0, addr_o=RESET_PC.
  - Reset mid-transaction drops everything. Late valid_i after reset is ignored only if discard>0; the memory wrapper is reset on the same RSTn.
- Issue:
  - proc_req_o = !redirect_i && outstanding<MAX_OUTSTANDING && (fifo_count+outstanding-discard)<DEPTH.
  - addr_o = fetch_pc.
  - On handshake: fetch_pc += 4, wraps modulo 2^XLEN; outstanding += 1.
  - proc_req_o and addr_o stay stable until accepted, unless redirected.
- Response:
  - On valid_i: outstanding -= 1.
  - If discard>0: discard -= 1 and data is dropped.
  - Otherwise push {rdata_i, pc_q} into the FIFO. pc_q is a per-request PC tag queue of depth MAX_OUTSTANDING.
  - Same-cycle handshake and valid_i: outstanding unchanged.
  - Memory-to-output latency: one cycle (response registered in FIFO, visible the next cycle).
- Output:
  - instr_valid_o = !fifo_empty. Head entry is held until instr_ready_i.
  - Pop on instr_valid_o & instr_ready_i.
  - Simultaneous push and pop on a full FIFO is legal. Push on full without pop is impossible by the issue rule; an assertion flags it.
- Redirect (highest priority):
  - FIFO flushed; fetch_pc = redirect_pc_i; discard = outstanding minus any response arriving this cycle.
  - No request is issued in the redirect cycle. The first new request goes out the next cycle.
  - A pop in the redirect cycle is ignored.
- FSM tracking fetch state:
  - RUN: normal operation.
  - DRAIN: discard>0; new requests are still allowed, bounded by outstanding.
  - DRAIN→RUN when discard reaches 0.
  - Redirect in either state → DRAIN if discard>0, else RUN.
- Counters are saturating-safe by construction. Widths are $clog2(DEPTH+1) and $clog2(MAX_OUTSTANDING+1).

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, discard=0 and valid_i=1, rdata_i and its PC are driven combinationally onto instr_o/instr_pc_o with instr_valid_o=1. The response is pushed only if instr_ready_i=0. Latency is 0 cycles.
- Undefined: always one cycle through the FIFO.

Decomposition:
- riscv_pkg holds: XLEN default; RESET_PC constant; typedef fetch_entry_t {instr, pc}; enum fetch_state_t {RUN, DRAIN}.
- Sub-module fetch_fifo: generic synchronous FIFO of fetch_entry_t with DEPTH, push/pop/full/empty/count and flush input. The PC tag queue reuses fetch_fifo with DEPTH=MAX_OUTSTANDING.

Test Plan:
- Reset release, mem_rdy_i=1, response 1 cycle after request, instr_ready_i=1 → addr_o sequence 0x00400000, 0x00400004, …; instr_pc_o follows with instr_valid_o high every cycle after fill.
- instr_ready_i=0 for 20 cycles, DEPTH=4 → exactly 4 requests accepted (MAX_OUTSTANDING=2 respected); proc_req_o=0 afterwards; release pops 0x00400000 first.
- Redirect to 0x00400100 with 2 outstanding → both responses dropped; next instr_pc_o is 0x00400100; state DRAIN for 2 responses then RUN.
- mem_rdy_i held 0 for 5 cycles → proc_req_o and addr_o stable at the same value; outstanding stays 0.
- redirect_i coincident with valid_i and instr_ready_i → the arriving response is discarded, discard=outstanding-1, no pop counted, FIFO empty next cycle.
- Build with FETCH_BYPASS_EN, FIFO empty → rdata_i=0x00000013 appears on instr_o in the same cycle as valid_i. Without the macro, it appears the next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path types: instruction/PC entry and the fetch FSM state.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0040_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; a pop on empty and a push on
// full without a matching pop are both ignored.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     din_i,
    input  logic             pop_i,
    output fetch_entry_t     dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; readers only look at it while the FIFO is non-empty.
    always_ff @(posedge CLK) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

    assert property (@(posedge CLK) disable iff (!RSTn)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Pipelined instruction prefetcher: in-order reads, DEPTH-entry buffer, redirect
// with stale-response discard. Optional macro FETCH_BYPASS_EN: zero-latency bypass.
module fetch_prefetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN            = riscv_pkg::XLEN,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = riscv_pkg::RESET_PC
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            instr_ready_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            busy_o,
    output logic            proc_req_o,
    input  logic            mem_rdy_i,
    output logic [XLEN-1:0] addr_o,
    output logic            we_o,
    output logic [XLEN-1:0] wdata_o,
    input  logic [XLEN-1:0] rdata_i,
    input  logic            valid_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0] discard_q, discard_d;
    fetch_state_t     state_q, state_d;

    logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    fetch_entry_t     fifo_din, fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             tag_full, tag_empty;
    fetch_entry_t     tag_din, tag_dout;
    logic [OUT_W-1:0] tag_count;
    logic             handshake, resp, bypass_hit;
    logic             unused_bits;

    // The tag queue holds one PC per accepted request, so its fill level is
    // the outstanding count; every response (kept or dropped) retires a tag.
    assign resp      = valid_i && !tag_empty;
    assign proc_req_o = RSTn && !redirect_i && !tag_full &&
                        ((int'(fifo_count) + int'(tag_count) - int'(discard_q)) < DEPTH);
    assign handshake = proc_req_o && mem_rdy_i;
    assign tag_din   = '{instr: '0, pc: fetch_pc_q};
    assign fifo_din  = '{instr: rdata_i, pc: tag_dout.pc};
    assign addr_o    = fetch_pc_q;
    assign we_o      = 1'b0;
    assign wdata_o   = '0;
    assign busy_o    = !instr_valid_o;
    assign unused_bits = ^{tag_dout.instr, fifo_full};

    fetch_fifo #(.DEPTH(DEPTH)) u_instr_fifo (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .flush_i (1'b0),
        .push_i  (handshake),
        .din_i   (tag_din),
        .pop_i   (resp),
        .dout_o  (tag_dout),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_count)
    );

    always_comb begin
        bypass_hit = 1'b0;
`ifdef FETCH_BYPASS_EN
        bypass_hit = fifo_empty && resp && (discard_q == '0) && !redirect_i;
`endif
        instr_valid_o = !fifo_empty || bypass_hit;
        instr_o       = '0;
        instr_pc_o    = '0;
        if (!fifo_empty) begin
            instr_o    = fifo_dout.instr;
            instr_pc_o = fifo_dout.pc;
        end else if (bypass_hit) begin
            instr_o    = rdata_i;
            instr_pc_o = tag_dout.pc;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        fifo_flush = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        if (redirect_i) begin
            // A response landing in the redirect cycle is already stale.
            fifo_flush = 1'b1;
            fetch_pc_d = redirect_pc_i;
            discard_d  = resp ? tag_count - OUT_W'(1) : tag_count;
        end else begin
            if (handshake) fetch_pc_d = fetch_pc_q + XLEN'(4);
            fifo_pop = !fifo_empty && instr_ready_i;
            if (resp) begin
                if (discard_q != '0) discard_d = discard_q - OUT_W'(1);
                else                 fifo_push = !(bypass_hit && instr_ready_i);
            end
        end

        state_d = state_q;
        case (state_q)
            RUN:     if (discard_d != '0) state_d = DRAIN;
            DRAIN:   if (discard_d == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
            state_q    <= RUN;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit against a queue-based model of the
// fetch stream (requests in flight, stale marking, expected output order).
module tb_fetch_prefetch_unit;
    import riscv_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    typedef struct packed {
        logic        stale;
        logic [31:0] addr;
    } req_t;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_ready_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        busy_o;
    logic        proc_req_o;
    logic        mem_rdy_i;
    logic [31:0] addr_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic [31:0] rdata_i;
    logic        valid_i;

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_hs    = 0;

    logic [31:0] env_q[$];
    req_t        m_out[$];
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;

    always #5 CLK = ~CLK;

    fetch_prefetch_unit #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_ready_i (instr_ready_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .busy_o        (busy_o),
        .proc_req_o    (proc_req_o),
        .mem_rdy_i     (mem_rdy_i),
        .addr_o        (addr_o),
        .we_o          (we_o),
        .wdata_o       (wdata_o),
        .rdata_i       (rdata_i),
        .valid_i       (valid_i)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    function automatic logic roll(input int pct);
        return ($urandom_range(1, 100) <= pct);
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTn          = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        mem_rdy_i     = 1'b0;
        valid_i       = 1'b0;
        rdata_i       = '0;
        @(posedge CLK);
        #1;
        check_val("rst_req",   proc_req_o,    0);
        check_val("rst_valid", instr_valid_o, 0);
        check_val("rst_busy",  busy_o,        1);
        check_val("rst_instr", instr_o,       0);
        check_val("rst_pc",    instr_pc_o,    0);
        check_val("rst_addr",  addr_o,        32'h0040_0000);
        check_val("rst_state", 64'(dut.state_q), 64'(RUN));
        env_q.delete();
        m_out.delete();
        exp_q.delete();
        m_pc = 32'h0040_0000;
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    // One clock: drive inputs, check outputs against the model, advance both.
    task automatic step(input int p_mrdy, input int p_vld, input int p_rdy,
                        input int p_red, input logic [31:0] rpc);
        int          stale;
        int          live;
        logic        exp_req, exp_valid, byp, resp;
        logic [63:0] head;
        req_t        r;
        @(negedge CLK);
        mem_rdy_i     = roll(p_mrdy);
        instr_ready_i = roll(p_rdy);
        redirect_i    = roll(p_red);
        redirect_pc_i = rpc;
        valid_i       = (env_q.size() > 0) && roll(p_vld);
        rdata_i       = valid_i ? mem_data(env_q[0]) : $urandom;
        #1;
        stale = 0;
        foreach (m_out[i]) if (m_out[i].stale) stale++;
        live    = m_out.size() - stale;
        resp    = valid_i && (m_out.size() > 0);
        exp_req = !redirect_i && (m_out.size() < MAX_OUT) && ((exp_q.size() + live) < DEPTH);
        byp     = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = (exp_q.size() == 0) && resp && !m_out[0].stale && !redirect_i;
`endif
        exp_valid = (exp_q.size() > 0) || byp;
        head = '0;
        if (exp_q.size() > 0) head = exp_q[0];
        else if (byp)         head = {mem_data(m_out[0].addr), m_out[0].addr};

        check_val("req",   proc_req_o,    exp_req);
        check_val("addr",  addr_o,        m_pc);
        check_val("valid", instr_valid_o, exp_valid);
        check_val("busy",  busy_o,        !exp_valid);
        check_val("instr", instr_o,       head[63:32]);
        check_val("ipc",   instr_pc_o,    head[31:0]);
        check_val("state", 64'(dut.state_q), (stale > 0) ? 64'(DRAIN) : 64'(RUN));
        check_val("we",    {we_o, wdata_o}, 0);

        if (valid_i) void'(env_q.pop_front());
        if (proc_req_o && mem_rdy_i) begin
            env_q.push_back(addr_o);
            n_hs++;
        end

        if (redirect_i) begin
            exp_q.delete();
            if (resp) void'(m_out.pop_front());
            foreach (m_out[i]) m_out[i].stale = 1'b1;
            m_pc = rpc;
        end else begin
            if ((exp_q.size() > 0) && instr_ready_i) void'(exp_q.pop_front());
            if (resp) begin
                r = m_out.pop_front();
                if (!r.stale && !(byp && instr_ready_i))
                    exp_q.push_back({mem_data(r.addr), r.addr});
            end
            if (exp_req && mem_rdy_i) begin
                m_out.push_back('{stale: 1'b0, addr: m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        int p_mrdy, p_vld, p_rdy, p_red;
        logic [31:0] rpc;

        // Streaming with one-cycle memory latency.
        do_reset();
        for (int i = 0; i < 20; i++) step(100, 100, 100, 0, '0);

        // Consumer stalled: buffer fills to DEPTH and requests stop.
        do_reset();
        n_hs = 0;
        for (int i = 0; i < 20; i++) step(100, 100, 0, 0, '0);
        check_val("stall_reqs", n_hs, 4);
        check_val("stall_req_low", proc_req_o, 0);
        check_val("stall_head", instr_pc_o, 32'h0040_0000);
        for (int i = 0; i < 10; i++) step(100, 100, 100, 0, '0);

        // Redirect with two requests in flight.
        do_reset();
        for (int i = 0; i < 3; i++) step(100, 0, 100, 0, '0);
        step(100, 0, 100, 100, 32'h0040_0100);
        for (int i = 0; i < 6; i++) step(100, 100, 0, 0, '0);
        check_val("redir_head", instr_pc_o, 32'h0040_0100);
        for (int i = 0; i < 6; i++) step(100, 100, 100, 0, '0);

        // Memory not ready: request and address hold.
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 100, 100, 0, '0);
        check_val("hold_req",  proc_req_o, 1);
        check_val("hold_addr", addr_o, 32'h0040_0000);

        // Redirect coinciding with a response and a ready consumer.
        do_reset();
        for (int i = 0; i < 3; i++) step(100, 0, 0, 0, '0);
        step(0, 100, 0, 0, '0);
        step(0, 100, 100, 100, 32'h0040_0200);
        step(0, 0, 100, 0, '0);
        check_val("coinc_empty", instr_valid_o, 0);
        for (int i = 0; i < 6; i++) step(100, 100, 100, 0, '0);

        // Address wrap past the top of the address space.
        step(100, 100, 100, 100, 32'hFFFF_FFF8);
        for (int i = 0; i < 10; i++) step(100, 100, 100, 0, '0);

        // Random traffic with occasional redirects and resets.
        for (int blk = 0; blk < 20; blk++) begin
            p_mrdy = $urandom_range(20, 100);
            p_vld  = $urandom_range(20, 100);
            p_rdy  = $urandom_range(10, 100);
            p_red  = $urandom_range(0, 10);
            for (int c = 0; c < 100; c++) begin
                if ($urandom_range(0, 299) == 0) do_reset();
                rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0
                    : 32'h0040_0000 + (32'($urandom_range(0, 1023)) << 2);
                step(p_mrdy, p_vld, p_rdy, p_red, rpc);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
